// File: rtl/rr_mux_pkg.sv
// Shared definitions for the four-way round-robin mux arbiter.
package rr_mux_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/MUX41.sv
// Single-bit 4:1 mux cell; sel 00..11 picks in0..in3.
module MUX41 (
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  input  logic [1:0] sel,
  output logic       y
);
  always_comb begin
    case (sel)
      2'b00:   y = in0;
      2'b01:   y = in1;
      2'b10:   y = in2;
      default: y = in3;
    endcase
  end
endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first asserted req at start, start+1, ... (mod 4).
module rr_pick4
  import rr_mux_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back to start so the nearest one wins.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = start + IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with hold-time limit sharing one DATA_W path via MUX41 cells.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  output logic [N_REQ-1:0]  gnt,
  output logic [IDX_W-1:0]  sel,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  last;
  logic [HOLD_W-1:0] hold_cnt;

  logic [N_REQ-1:0]  pick_req;
  logic [IDX_W-1:0]  pick_start;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;

  // The owner is masked out so the same search serves IDLE grant, release and rotation.
  assign pick_req   = req & ~gnt;
  assign pick_start = last + IDX_W'(1);

  rr_pick4 u_pick (
    .req   (pick_req),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      gnt        <= '0;
      sel        <= '0;
      last       <= IDX_W'(N_REQ - 1);
      hold_cnt   <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state      <= OWN;
            gnt        <= idx_to_onehot(pick_idx);
            sel        <= pick_idx;
            last       <= pick_idx;
            hold_cnt   <= '0;
            dout_valid <= 1'b1;
          end
        end
        OWN: begin
          if (req[sel]) begin
            // A saturated counter also counts as expired once someone else shows up.
            if (pick_found && hold_cnt >= HOLD_LAST) begin
              gnt      <= idx_to_onehot(pick_idx);
              sel      <= pick_idx;
              last     <= pick_idx;
              hold_cnt <= '0;
            end else if (hold_cnt != HOLD_SAT) begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end else if (pick_found) begin
            gnt      <= idx_to_onehot(pick_idx);
            sel      <= pick_idx;
            last     <= pick_idx;
            hold_cnt <= '0;
          end else begin
            state      <= IDLE;
            gnt        <= '0;
            hold_cnt   <= '0;
            dout_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar b = 0; b < DATA_W; b++) begin : g_mux
    MUX41 u_mux41 (
      .in0 (din0[b]),
      .in1 (din1[b]),
      .in2 (din2[b]),
      .in3 (din3[b]),
      .sel (sel),
      .y   (dout[b])
    );
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: MAX_HOLD=4 main instance plus a MAX_HOLD=1 instance.
module tb_rr_mux_arbiter;
  localparam int MAXH = 4;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    logic [3:0] d;
  } obs_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] din0 = 4'd1, din1 = 4'd2, din2 = 4'd4, din3 = 4'd8;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic [3:0] dout_a, dout_b;
  logic       dv_a, dv_b;

  int total = 0;
  int bad   = 0;
  obs_t exp_q[$];
  obs_t e, o;

  bit       m_own;
  int       m_sel, m_last, m_hold;

  always #5 CLK = ~CLK;

  rr_mux_arbiter #(.DATA_W(4), .MAX_HOLD(MAXH)) dut_a (
    .CLK(CLK), .RESET(RESET), .req(req),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .gnt(gnt_a), .sel(sel_a), .dout(dout_a), .dout_valid(dv_a)
  );

  rr_mux_arbiter #(.DATA_W(4), .MAX_HOLD(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .req(req),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .gnt(gnt_b), .sel(sel_b), .dout(dout_b), .dout_valid(dv_b)
  );

  function automatic obs_t snap_a();
    return '{g: gnt_a, s: sel_a, v: dv_a, d: dout_a};
  endfunction

  function automatic obs_t snap_b();
    return '{g: gnt_b, s: sel_b, v: dv_b, d: dout_b};
  endfunction

  function automatic obs_t mk(input logic [3:0] g, input logic [1:0] s, input logic v);
    return '{g: g, s: s, v: v, d: 4'(1 << s)};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    m_own = 1'b0; m_sel = 0; m_last = 3; m_hold = 0;
  endtask

  // Reference model of one rising edge, written from the arbitration rules.
  task automatic model_edge(input logic [3:0] r);
    int w;
    logic [3:0] cand;
    cand = m_own ? (r & ~(4'b0001 << m_sel)) : r;
    w = -1;
    for (int off = 1; off <= 4; off++) begin
      if (w < 0 && cand[(m_last + off) % 4]) w = (m_last + off) % 4;
    end
    if (!m_own) begin
      if (w >= 0) begin m_own = 1'b1; m_sel = w; m_last = w; m_hold = 0; end
    end else if (r[m_sel]) begin
      if (w >= 0 && m_hold >= MAXH - 1) begin m_sel = w; m_last = w; m_hold = 0; end
      else if (m_hold < MAXH) m_hold++;
    end else if (w >= 0) begin
      m_sel = w; m_last = w; m_hold = 0;
    end else begin
      m_own = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0));
    #1;
    e = exp_q.pop_front(); o = snap_a(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_state: got %p want %p", o, e); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1));
    step();
    e = exp_q.pop_front(); o = snap_a(); total++;
    if (o !== e) begin bad++; $display("FAIL single_grant: got %p want %p", o, e); end
    req = 4'b0000;
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0));
    step();
    e = exp_q.pop_front(); o = snap_a(); total++;
    if (o !== e) begin bad++; $display("FAIL single_release: got %p want %p", o, e); end
  endtask

  task automatic test_rotation();
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++)
      for (int c = 0; c < MAXH; c++)
        exp_q.push_back(mk(seq[i], 2'(i % 4), 1'b1));
    for (int n = 0; n < 5 * MAXH; n++) begin
      step();
      e = exp_q.pop_front(); o = snap_a(); total++;
      if (o !== e) begin bad++; $display("FAIL rotation cyc%0d: got %p want %p", n, o, e); end
    end
  endtask

  task automatic test_saturate();
    int waited;
    do_reset();
    req = 4'b0001;
    for (int n = 0; n < 10; n++) exp_q.push_back(mk(4'b0001, 2'd0, 1'b1));
    for (int n = 0; n < 10; n++) begin
      step();
      e = exp_q.pop_front(); o = snap_a(); total++;
      if (o !== e) begin bad++; $display("FAIL sat_alone cyc%0d: got %p want %p", n, o, e); end
    end
    req = 4'b0101;
    exp_q.push_back(mk(4'b0100, 2'd2, 1'b1));
    waited = 0;
    for (int n = 0; n < MAXH; n++) begin
      if (gnt_a !== 4'b0100) begin step(); waited++; end
    end
    e = exp_q.pop_front(); o = snap_a(); total++;
    if (o !== e) begin bad++; $display("FAIL sat_takeover after %0d cyc: got %p want %p", waited, o, e); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0010;
    exp_q.push_back(mk(4'b0010, 2'd1, 1'b1));
    exp_q.push_back(mk(4'b0010, 2'd1, 1'b1));
    exp_q.push_back(mk(4'b1000, 2'd3, 1'b1));
    step();
    e = exp_q.pop_front(); o = snap_a(); total++;
    if (o !== e) begin bad++; $display("FAIL b2b_own1: got %p want %p", o, e); end
    req = 4'b1010;
    step();
    e = exp_q.pop_front(); o = snap_a(); total++;
    if (o !== e) begin bad++; $display("FAIL b2b_pending: got %p want %p", o, e); end
    req = 4'b1000;
    step();
    e = exp_q.pop_front(); o = snap_a(); total++;
    if (o !== e) begin bad++; $display("FAIL b2b_handover: got %p want %p", o, e); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100;
    exp_q.push_back(mk(4'b0100, 2'd2, 1'b1));
    step();
    e = exp_q.pop_front(); o = snap_a(); total++;
    if (o !== e) begin bad++; $display("FAIL areset_pre: got %p want %p", o, e); end
    #2;
    RESET = 1'b1;
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0));
    #1;
    e = exp_q.pop_front(); o = snap_a(); total++;
    if (o !== e) begin bad++; $display("FAIL areset_immediate: got %p want %p", o, e); end
    req = 4'b0110;
    @(negedge CLK);
    RESET = 1'b0;
    exp_q.push_back(mk(4'b0010, 2'd1, 1'b1));
    step();
    e = exp_q.pop_front(); o = snap_a(); total++;
    if (o !== e) begin bad++; $display("FAIL areset_first_grant: got %p want %p", o, e); end
  endtask

  task automatic test_max_hold1();
    do_reset();
    req = 4'b0011;
    for (int n = 0; n < 8; n++)
      exp_q.push_back(mk((n % 2 == 0) ? 4'b0001 : 4'b0010, 2'(n % 2), 1'b1));
    for (int n = 0; n < 8; n++) begin
      step();
      e = exp_q.pop_front(); o = snap_b(); total++;
      if (o !== e) begin bad++; $display("FAIL hold1 cyc%0d: got %p want %p", n, o, e); end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      r = 4'($urandom_range(0, 15));
      if (n % 50 < 20) r = r | 4'b0011;
      req = r;
      model_edge(r);
      exp_q.push_back(mk(m_own ? 4'(1 << m_sel) : 4'b0000, 2'(m_sel), m_own));
      step();
      e = exp_q.pop_front(); o = snap_a(); total++;
      if (o !== e) begin bad++; $display("FAIL random cyc%0d req=%b: got %p want %p", n, r, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_saturate();
    test_back_to_back();
    test_async_reset();
    test_max_hold1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
